// File: rtl/word_ser_tx.sv
// Word serializer: frames a DW-bit word as start(0), data MSB first,
// optional even parity, stop(1), with each bit held for DIV clocks.
module word_ser_tx #(
    parameter int DW        = 16,
    parameter int DIV       = 4,
    parameter int PARITY_EN = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_vld,
    input  logic [DW-1:0] i_dat,
    output logic          o_rdy,
    output logic          o_sdo,
    output logic          o_busy,
    output logic          o_done
);
    localparam int DVW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW  = $clog2(DW);
    localparam logic [DVW-1:0] DIV_LAST = DVW'(DIV - 1);
    localparam logic [BW-1:0]  BIT_LAST = BW'(DW - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t          state_q, state_d;
    logic [DVW-1:0]  div_q, div_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic [DW-1:0]   sh_q, sh_d;
    logic            par_q, par_d;
    logic            sdo_q, sdo_d;
    logic            done_q, done_d;
    logic            div_last;

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        bit_d    = bit_q;
        sh_d     = sh_q;
        par_d    = par_q;
        div_last = (div_q == DIV_LAST);

        case (state_q)
            IDLE: begin
                if (i_vld) begin
                    state_d = START;
                    div_d   = '0;
                    bit_d   = '0;
                    sh_d    = i_dat;
                    par_d   = ^i_dat;
                end
            end
            START: begin
                if (div_last) begin
                    state_d = DATA;
                    div_d   = '0;
                    bit_d   = '0;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            DATA: begin
                if (div_last) begin
                    div_d = '0;
                    if (bit_q == BIT_LAST) begin
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 1'b1;
                        sh_d  = {sh_q[DW-2:0], 1'b0};
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            PARITY: begin
                if (div_last) begin
                    state_d = STOP;
                    div_d   = '0;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            STOP: begin
                if (div_last) begin
                    state_d = IDLE;
                    div_d   = '0;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                div_d   = '0;
                bit_d   = '0;
            end
        endcase
    end

    // Line level and done pulse are decoded from the next state so that the
    // registered outputs line up with the state they belong to.
    always_comb begin
        sdo_d = 1'b1;
        case (state_d)
            START:   sdo_d = 1'b0;
            DATA:    sdo_d = sh_d[DW-1];
            PARITY:  sdo_d = par_d;
            default: sdo_d = 1'b1;
        endcase
        done_d = (state_d == STOP) && (div_d == DIV_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            par_q   <= 1'b0;
            sdo_q   <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            par_q   <= par_d;
            sdo_q   <= sdo_d;
            done_q  <= done_d;
        end
    end

    assign o_rdy  = (state_q == IDLE);
    assign o_busy = ~o_rdy;
    assign o_sdo  = sdo_q;
    assign o_done = done_q;
endmodule

// File: doc/word_ser_tx.md
WORD_SER_TX -- requirements
Module: word_ser_tx

Interface
REQ-001 SHALL have parameter DW, default 16, parallel word width in bits (DW >= 2).
REQ-002 SHALL have parameter DIV, default 4, clock cycles per serial bit (DIV >= 1).
REQ-003 SHALL have parameter PARITY_EN, default 1: 1 = even-parity bit appended, 0 = no parity bit.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port i_vld  input  1  word offered on i_dat.
REQ-007 SHALL have port i_dat  input  DW  parallel word to serialize.
REQ-008 SHALL have port o_rdy  output  1  transmitter idle, can accept a word.
REQ-009 SHALL have port o_sdo  output  1  serial data line, registered.
REQ-010 SHALL have port o_busy  output  1  frame in progress.
REQ-011 SHALL have port o_done  output  1  one-cycle frame-complete pulse, registered.

Function
REQ-012 SHALL frame each word as: start bit 0, DW data bits MSB first, parity bit if PARITY_EN, stop bit 1; idle line level is 1.
REQ-013 SHALL hold every frame bit on o_sdo for exactly DIV clock cycles.
REQ-014 SHALL implement states IDLE, START, DATA, PARITY, STOP; IDLE->START on accept; START->DATA after DIV cycles; DATA->PARITY (PARITY_EN=1) or DATA->STOP (PARITY_EN=0) after DW*DIV cycles; PARITY->STOP after DIV cycles; STOP->IDLE after DIV cycles.
REQ-015 SHALL drive o_rdy = 1 only in IDLE, combinationally from state; o_busy = not o_rdy.
REQ-016 SHALL accept a word when i_vld and o_rdy are both 1 at a rising edge, capturing i_dat into an internal shift register at that edge.
REQ-017 SHALL ignore i_vld and i_dat in any state other than IDLE; changes to i_dat after acceptance SHALL NOT affect the frame.
REQ-018 SHALL drive o_sdo low starting the first cycle after the accept edge (latency 1 cycle).
REQ-019 SHALL compute the parity bit as XOR of all DW captured data bits (total ones in data+parity even).
REQ-020 SHALL use a divider counter 0..DIV-1 and a bit counter 0..DW-1; both SHALL clear on state entry; with DIV=1 every bit lasts exactly one cycle.
REQ-021 SHALL assert o_done for exactly one cycle, the last cycle of the stop bit; o_rdy SHALL be 1 the following cycle.
REQ-022 SHALL give a frame length F = (DW+2+PARITY_EN)*DIV cycles and minimum accept-to-accept spacing F+1 cycles with i_vld held high.

Reset
REQ-023 SHALL, while rst = 1 and immediately on its assertion, force state IDLE, o_sdo = 1, o_done = 0, o_busy = 0, o_rdy = 1, counters and shift register = 0.
REQ-024 SHALL, on rst asserted mid-frame, abort the frame without an o_done pulse; no partial frame resumes after release.
REQ-025 SHALL be able to accept a word on the first rising edge after rst deasserts.

Verification
REQ-026 SHALL cover: DW=16, DIV=4, PARITY_EN=1, accept 16'hA5C3 -> o_sdo = 0, 1010010111000011, parity 0, stop 1, each bit 4 cycles; o_done high in cycle 76 after accept; o_rdy high cycle 77.
REQ-027 SHALL cover: same config, 16'h0001 -> parity bit 1; 16'h0000 -> parity bit 0.
REQ-028 SHALL cover: i_vld held high with 16'h1234 then 16'hFFFF -> second accept exactly 77 cycles after first; o_sdo stays 1 for the single idle cycle between frames.
REQ-029 SHALL cover: i_vld pulsed with 16'h5555 during DATA of a 16'hA5C3 frame -> ignored; line output identical to REQ-026.
REQ-030 SHALL cover: rst asserted during data bit 5 -> o_sdo = 1 asynchronously, no o_done, o_rdy = 1; fresh 16'hA5C3 after release sent intact.
REQ-031 SHALL cover: DW=16, DIV=1, PARITY_EN=0, 16'h8000 -> 18-cycle frame 0,1,0x15,1; o_done in cycle 18.
